ssp_reg_master: RTL

Initiator-side sequencer for the SSP register interface of `ssp_uart`. It accepts register-access requests (address, direction, write data) on a valid/ready port and converts each one into a single SSP frame on `SSP_SSEL`/`SSP_RA`/`SSP_WnR`/`SSP_DI`/`SSP_EOC`. After the access it samples `SSP_DO` and returns it on a valid/ready response port. It sits between a host/CPU-side agent and `ssp_uart`, and replaces the hand-driven frames currently used in bench bring-up.

---
 rtl/ssp_pkg.sv | 46 ++++
 rtl/ssp_reg_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ssp_pkg.sv
// -----------------------------------------------------------------------------
// ssp_pkg
// Shared definitions for the SSP register interface of ssp_uart: bus widths,
// register addresses, the initiator FSM state encoding and the request/response
// records exchanged with the host side.
// No ports (package).
// -----------------------------------------------------------------------------
package ssp_pkg;

    localparam int SSP_RA_W = 3;
    localparam int SSP_D_W  = 12;

    // Register map of ssp_uart
    localparam logic [SSP_RA_W-1:0] SSP_REG_UCR = 3'd0;
    localparam logic [SSP_RA_W-1:0] SSP_REG_USR = 3'd1;
    localparam logic [SSP_RA_W-1:0] SSP_REG_TDR = 3'd2;
    localparam logic [SSP_RA_W-1:0] SSP_REG_RDR = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4,
        ST_GAP    = 3'd5
    } ssp_mst_state_e;

    typedef struct packed {
        logic [SSP_RA_W-1:0] ra;
        logic                wnr;
        logic [SSP_D_W-1:0]  wdata;
    } ssp_req_t;

    typedef struct packed {
        logic [SSP_RA_W-1:0] ra;
        logic                wnr;
        logic [SSP_D_W-1:0]  rdata;
        logic                mismatch;
    } ssp_rsp_t;

    // States in which a frame is driven onto the SSP bus (SSP_SSEL high)
    function automatic logic in_frame(input ssp_mst_state_e s);
        return (s == ST_SETUP) || (s == ST_ACCESS) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/ssp_reg_master.sv
// -----------------------------------------------------------------------------
// ssp_reg_master
// Initiator-side sequencer: turns one valid/ready register request into one SSP
// frame, samples SSP_DO after the access and returns it on a valid/ready
// response port. Writes return their readback and flag a readback mismatch.
// Ports:
//   Clk, Rst                         clock, asynchronous active-low reset
//   req_valid/req_ready/req_ra/
//   req_wnr/req_wdata                request channel
//   rsp_valid/rsp_ready/rsp_ra/
//   rsp_wnr/rsp_rdata/rsp_mismatch   response channel
//   busy                             FSM not in IDLE
//   SSP_SSEL/SSP_RA/SSP_WnR/SSP_EOC/
//   SSP_DI/SSP_DO                    SSP register bus to ssp_uart
// All outputs are registers decoded from the next state, so they change on the
// same edge as the FSM and clear asynchronously on reset.
// -----------------------------------------------------------------------------
module ssp_reg_master
    import ssp_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned GAP_CYC   = 1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SSP_RA_W-1:0] req_ra,
    input  logic                req_wnr,
    input  logic [SSP_D_W-1:0]  req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SSP_RA_W-1:0] rsp_ra,
    output logic                rsp_wnr,
    output logic [SSP_D_W-1:0]  rsp_rdata,
    output logic                rsp_mismatch,
    output logic                busy,
    output logic                SSP_SSEL,
    output logic [SSP_RA_W-1:0] SSP_RA,
    output logic                SSP_WnR,
    output logic                SSP_EOC,
    output logic [SSP_D_W-1:0]  SSP_DI,
    input  logic [SSP_D_W-1:0]  SSP_DO
);

    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC);
    localparam logic [7:0] READ_LD  = 8'(READ_LAT);
    localparam logic [7:0] GAP_LD   = 8'(GAP_CYC);

    ssp_mst_state_e r_state;
    ssp_mst_state_e w_state_nxt;
    logic [7:0]     r_cnt;
    logic [7:0]     w_cnt_nxt;
    logic           w_capture;
    logic           w_sample;
    logic           w_frame_nxt;
    ssp_req_t       r_req;
    ssp_req_t       w_req_in;
    ssp_req_t       w_req_cur;
    ssp_rsp_t       r_rsp;

    logic                r_req_ready;
    logic                r_rsp_valid;
    logic                r_busy;
    logic                r_ssel;
    logic                r_eoc;
    logic [SSP_RA_W-1:0] r_ssp_ra;
    logic                r_ssp_wnr;
    logic [SSP_D_W-1:0]  r_ssp_di;

    // Next-state and shared down-counter; every timed state exits when the
    // counter reads 1, so a load of N gives exactly N cycles in that state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_req_ready is low for the first cycle after reset release
                if (r_req_ready && req_valid) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = SETUP_LD;
                    w_capture   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (r_cnt == 8'd1) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = READ_LD;
            end
            ST_WAIT: begin
                if (r_cnt == 8'd1) begin
                    w_state_nxt = ST_RESP;
                    w_sample    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (GAP_LD == 8'd0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_cnt_nxt   = GAP_LD;
                    end
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_GAP: begin
                if (r_cnt == 8'd1) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Request seen by the bus registers: the incoming one on the accept edge,
    // otherwise the captured copy.
    always_comb begin
        w_req_in.ra    = req_ra;
        w_req_in.wnr   = req_wnr;
        w_req_in.wdata = req_wdata;
        if (w_capture) begin
            w_req_cur = w_req_in;
        end else begin
            w_req_cur = r_req;
        end
        w_frame_nxt = in_frame(w_state_nxt);
    end

    // FSM state and counter
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Request capture and response sampling at the end of WAIT
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_req <= '0;
            r_rsp <= '0;
        end else begin
            r_req <= w_req_cur;
            if (w_sample) begin
                r_rsp.ra       <= r_req.ra;
                r_rsp.wnr      <= r_req.wnr;
                r_rsp.rdata    <= SSP_DO;
                r_rsp.mismatch <= r_req.wnr && (SSP_DO != r_req.wdata);
            end else begin
                r_rsp <= r_rsp;
            end
        end
    end

    // Output registers decoded from the next state
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ssel      <= 1'b0;
            r_eoc       <= 1'b0;
            r_ssp_ra    <= '0;
            r_ssp_wnr   <= 1'b0;
            r_ssp_di    <= '0;
        end else begin
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_ssel      <= w_frame_nxt;
            r_eoc       <= (w_state_nxt == ST_ACCESS);
            r_ssp_ra    <= w_frame_nxt ? w_req_cur.ra    : {SSP_RA_W{1'b0}};
            r_ssp_wnr   <= w_frame_nxt ? w_req_cur.wnr   : 1'b0;
            r_ssp_di    <= w_frame_nxt ? w_req_cur.wdata : {SSP_D_W{1'b0}};
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_ra       = r_rsp.ra;
    assign rsp_wnr      = r_rsp.wnr;
    assign rsp_rdata    = r_rsp.rdata;
    assign rsp_mismatch = r_rsp.mismatch;
    assign busy         = r_busy;
    assign SSP_SSEL     = r_ssel;
    assign SSP_RA       = r_ssp_ra;
    assign SSP_WnR      = r_ssp_wnr;
    assign SSP_EOC      = r_eoc;
    assign SSP_DI       = r_ssp_di;

endmodule
